s1494_scan_ctrl: RTL and testbench
==================================

S1494_SCAN_CTRL -- requirements
Module: s1494_scan_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 7, functional primary-input width.
REQ-002 SHALL have parameter STATE_W, default 6, state-register width.
REQ-003 SHALL have parameter OUT_W, default 19, primary-output width.
REQ-004 SHALL have parameter SIG_W, default 16, PRPG/MISR width; IN_W <= SIG_W.
REQ-005 SHALL have parameter POLY, default 16'hB400, Galois feedback polynomial.
REQ-006 SHALL have parameter SEED, default 16'hACE1, PRPG reset value.
REQ-007 SHALL have parameter BIST_LEN, default 256, BIST pattern count, >= 1.
REQ-008 SHALL have port CLK, in, 1, the single clock; all state is rising-edge.
REQ-009 SHALL have port CLR, in, 1, synchronous active-high reset.
REQ-010 SHALL have port mode, in, 2, 00 FUNC, 01 SHIFT, 10 HOLD, 11 BIST.
REQ-011 SHALL have port pi, in, IN_W, functional inputs.
REQ-012 SHALL have port scan_in, in, 1, serial scan data.
REQ-013 SHALL have port bist_start, in, 1, single-cycle BIST launch pulse.
REQ-014 SHALL have port po, out, OUT_W, registered outputs.
REQ-015 SHALL have port state, out, STATE_W, state-register contents.
REQ-016 SHALL have port scan_out, out, 1, state[STATE_W-1].
REQ-017 SHALL have ports sig, out, SIG_W, MISR value, and bist_busy/sig_valid, out, 1 each.

Function
REQ-018 SHALL compute {ns, npo} combinationally from (pi_eff, state) in sub-module s1494_ns_logic; pi_eff = pi in FUNC and PRPG[IN_W-1:0] during BIST run.
REQ-019 FUNC: each cycle state<=ns, po<=npo; one-cycle latency pi to po.
REQ-020 SHIFT: state<={state[STATE_W-2:0], scan_in}; po holds; scan_out = old MSB, so STATE_W cycles load a full vector.
REQ-021 HOLD: state, po, sig, PRPG all hold.
REQ-022 SHALL run controller FSM IDLE, RUN, DONE; IDLE->RUN on bist_start while mode==11; RUN->DONE after exactly BIST_LEN RUN cycles; DONE->IDLE after one cycle.
REQ-023 On the IDLE->RUN edge, SHALL load PRPG=SEED, sig=0, pattern counter=0.
REQ-024 In RUN, each cycle: state<=ns, po<=npo, PRPG<=galois(PRPG), sig<=galois(sig) XOR fold(npo), counter+1.
REQ-025 galois(x) = (x>>1) XOR (x[0] ? POLY : 0); fold(v)[i] = XOR of v[j] for all j with j mod SIG_W == i.
REQ-026 bist_busy SHALL be 1 exactly in RUN; sig_valid SHALL be 1 exactly in DONE, sig stable from DONE until next launch.
REQ-027 mode leaving 11 while RUN SHALL abort to IDLE next cycle, sig_valid never asserted for that run, sig frozen at abort value.
REQ-028 bist_start while RUN/DONE or mode!=11 SHALL be ignored.
REQ-029 In mode 11 outside RUN, state, po, PRPG and sig SHALL hold.
REQ-030 Counter SHALL be ceil(log2(BIST_LEN+1)) bits, no wrap within a run.

Reset
REQ-031 CLR=1 at a rising edge SHALL set state=0, po=0, sig=0, PRPG=SEED, counter=0, FSM=IDLE, bist_busy=0, sig_valid=0.
REQ-032 CLR SHALL dominate mode and bist_start in the same cycle, including mid-RUN.

Structure
REQ-033 Mode encodings, FSM state typedef, galois and fold functions SHALL reside in package s1494_scan_pkg.
REQ-034 The only sub-module SHALL be s1494_ns_logic (pure combinational cone, netlist-swappable).

Verification
REQ-035 CLR high 2 cycles, mode=00 -> state=0, po=0, sig=0, bist_busy=0, scan_out=0.
REQ-036 mode=01, scan_in 1,0,1,1,0,1 over 6 cycles -> state=6'b101101; next 6 cycles scan_out emits 1,0,1,1,0,1.
REQ-037 Stub ns=state+pi[5:0], npo={13'b0,state}; FUNC pi=1 for 5 cycles from 0 -> state=5, po[5:0]=4.
REQ-038 mode=11, bist_start pulse, BIST_LEN=4 -> bist_busy 4 cycles, sig_valid 1 cycle, sig equals model of REQ-024/025 from SEED.
REQ-039 mode 11->10 after 2 RUN cycles -> IDLE, sig_valid stays 0, sig holds 2-step value.
REQ-040 CLR pulse on 3rd RUN cycle -> next cycle all outputs at REQ-031 values, IDLE.

Source files
------------

// File: rtl/s1494_scan_pkg.sv
// s1494_scan_pkg: mode and controller encodings plus the LFSR/MISR helpers.
package s1494_scan_pkg;

    typedef enum logic [1:0] {
        M_FUNC  = 2'b00,
        M_SHIFT = 2'b01,
        M_HOLD  = 2'b10,
        M_BIST  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    localparam int MAX_SIG = 64;
    localparam int MAX_VEC = 128;

    // Widths are zero-extended to MAX_SIG, so a right shift never pulls in stray bits.
    function automatic logic [MAX_SIG-1:0] galois(input logic [MAX_SIG-1:0] x,
                                                  input logic [MAX_SIG-1:0] poly);
        return (x >> 1) ^ (x[0] ? poly : '0);
    endfunction

    function automatic logic [MAX_SIG-1:0] fold(input logic [MAX_VEC-1:0] v, input int w);
        logic [MAX_SIG-1:0] f;
        f = '0;
        for (int j = 0; j < MAX_VEC; j++) f[6'(j % w)] = f[6'(j % w)] ^ v[j];
        return f;
    endfunction

endpackage

// File: rtl/s1494_ns_logic.sv
// s1494_ns_logic: combinational next-state/output cone; replaceable by the real netlist.
module s1494_ns_logic #(
    parameter int IN_W    = 7,
    parameter int STATE_W = 6,
    parameter int OUT_W   = 19
) (
    input  logic [IN_W-1:0]    pi,
    input  logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] ns,
    output logic [OUT_W-1:0]   npo
);

    assign ns  = state + STATE_W'(pi);
    assign npo = OUT_W'(state);

endmodule

// File: rtl/s1494_scan_ctrl.sv
// s1494_scan_ctrl: functional/scan/hold/BIST wrapper around the s1494 cone,
// with a PRPG driving the inputs and a MISR compacting the outputs during BIST.
module s1494_scan_ctrl
    import s1494_scan_pkg::*;
#(
    parameter int                IN_W     = 7,
    parameter int                STATE_W  = 6,
    parameter int                OUT_W    = 19,
    parameter int                SIG_W    = 16,
    parameter logic [SIG_W-1:0]  POLY     = 16'hB400,
    parameter logic [SIG_W-1:0]  SEED     = 16'hACE1,
    parameter int                BIST_LEN = 256
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [1:0]         mode,
    input  logic [IN_W-1:0]    pi,
    input  logic               scan_in,
    input  logic               bist_start,
    output logic [OUT_W-1:0]   po,
    output logic [STATE_W-1:0] state,
    output logic               scan_out,
    output logic [SIG_W-1:0]   sig,
    output logic               bist_busy,
    output logic               sig_valid
);

    localparam int CNT_W = $clog2(BIST_LEN + 1);

    fsm_e               fsm;
    logic [SIG_W-1:0]   prpg;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    pi_eff;
    logic [STATE_W-1:0] ns;
    logic [OUT_W-1:0]   npo;
    logic               run;
    logic               bist;

    assign run      = fsm == S_RUN;
    assign bist     = mode == M_BIST;
    assign pi_eff   = run ? prpg[IN_W-1:0] : pi;
    assign scan_out = state[STATE_W-1];

    s1494_ns_logic #(
        .IN_W    (IN_W),
        .STATE_W (STATE_W),
        .OUT_W   (OUT_W)
    ) u_ns (
        .pi    (pi_eff),
        .state (state),
        .ns    (ns),
        .npo   (npo)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            fsm       <= S_IDLE;
            state     <= '0;
            po        <= '0;
            sig       <= '0;
            prpg      <= SEED;
            cnt       <= '0;
            bist_busy <= 1'b0;
            sig_valid <= 1'b0;
        end else if (run) begin
            // Leaving BIST mode mid-run aborts with every register frozen.
            if (!bist) begin
                fsm       <= S_IDLE;
                bist_busy <= 1'b0;
            end else begin
                state <= ns;
                po    <= npo;
                prpg  <= SIG_W'(galois(MAX_SIG'(prpg), MAX_SIG'(POLY)));
                sig   <= SIG_W'(galois(MAX_SIG'(sig), MAX_SIG'(POLY)) ^ fold(MAX_VEC'(npo), SIG_W));
                cnt   <= cnt + 1'b1;
                if (cnt == CNT_W'(BIST_LEN - 1)) begin
                    fsm       <= S_DONE;
                    bist_busy <= 1'b0;
                    sig_valid <= 1'b1;
                end
            end
        end else begin
            if (mode == M_FUNC) begin
                state <= ns;
                po    <= npo;
            end else if (mode == M_SHIFT) begin
                state <= {state[STATE_W-2:0], scan_in};
            end
            if (fsm == S_DONE) begin
                fsm       <= S_IDLE;
                sig_valid <= 1'b0;
            end else if (bist && bist_start) begin
                fsm       <= S_RUN;
                bist_busy <= 1'b1;
                prpg      <= SEED;
                sig       <= '0;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_s1494_scan_ctrl.sv
// tb_s1494_scan_ctrl: directed vectors against a cycle model of the scan/BIST rules,
// plus hand-computed literal expectations (BIST_LEN=4 signature from SEED is 16'hEE09).
module tb_s1494_scan_ctrl;

    localparam int          IN_W     = 7;
    localparam int          STATE_W  = 6;
    localparam int          OUT_W    = 19;
    localparam int          SIG_W    = 16;
    localparam int          BIST_LEN = 4;
    localparam logic [15:0] POLY     = 16'hB400;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic              CLK = 1'b0;
    logic              CLR = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic [IN_W-1:0]   pi = '0;
    logic              scan_in = 1'b0;
    logic              bist_start = 1'b0;
    logic [OUT_W-1:0]  po;
    logic [STATE_W-1:0] state;
    logic              scan_out;
    logic [SIG_W-1:0]  sig;
    logic              bist_busy;
    logic              sig_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    s1494_scan_ctrl #(
        .IN_W(IN_W), .STATE_W(STATE_W), .OUT_W(OUT_W), .SIG_W(SIG_W),
        .POLY(POLY), .SEED(SEED), .BIST_LEN(BIST_LEN)
    ) dut (
        .CLK(CLK), .CLR(CLR), .mode(mode), .pi(pi), .scan_in(scan_in),
        .bist_start(bist_start), .po(po), .state(state), .scan_out(scan_out),
        .sig(sig), .bist_busy(bist_busy), .sig_valid(sig_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Behavioural model: m_left counts remaining BIST patterns, m_done marks the one result cycle.
    logic [5:0]  m_state;
    logic [18:0] m_po, m_npo;
    logic [15:0] m_sig, m_prpg;
    int          m_left;
    bit          m_done, m_was_done;

    function automatic logic [15:0] gal(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? POLY : 16'h0);
    endfunction

    function automatic logic [15:0] fld(input logic [18:0] v);
        logic [15:0] f;
        f = '0;
        for (int j = 0; j < 19; j++) f[j % 16] = f[j % 16] ^ v[j];
        return f;
    endfunction

    always @(posedge CLK) begin
        if (CLR) begin
            m_state = '0; m_po = '0; m_sig = '0; m_prpg = SEED; m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            if (mode != 2'b11) begin
                m_left = 0;
            end else begin
                m_npo   = 19'(m_state);
                m_sig   = gal(m_sig) ^ fld(m_npo);
                m_state = m_state + m_prpg[5:0];
                m_prpg  = gal(m_prpg);
                m_po    = m_npo;
                m_left  = m_left - 1;
                m_done  = (m_left == 0);
            end
        end else begin
            m_was_done = m_done;
            m_done = 1'b0;
            if (mode == 2'b00) begin
                m_po    = 19'(m_state);
                m_state = m_state + pi[5:0];
            end else if (mode == 2'b01) begin
                m_state = {m_state[4:0], scan_in};
            end
            if (!m_was_done && mode == 2'b11 && bist_start) begin
                m_left = BIST_LEN; m_prpg = SEED; m_sig = '0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("po", 32'(po), 32'(m_po));
            chk("scan_out", 32'(scan_out), 32'(m_state[5]));
            chk("sig", 32'(sig), 32'(m_sig));
            chk("bist_busy", 32'(bist_busy), 32'(m_left > 0));
            chk("sig_valid", 32'(sig_valid), 32'(m_done));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_and_launch();
        CLR = 1'b1; cyc(1);
        CLR = 1'b0; mode = 2'b11; bist_start = 1'b1; cyc(1);
        bist_start = 1'b0;
    endtask

    logic [5:0] shift_vec;

    initial begin
        CLR = 1'b1; mode = 2'b00; cyc(2);
        chk_en = 1'b1;
        chk("rst_state", 32'(state), 0);
        chk("rst_po", 32'(po), 0);
        chk("rst_sig", 32'(sig), 0);
        chk("rst_busy", 32'(bist_busy), 0);
        chk("rst_scan_out", 32'(scan_out), 0);

        CLR = 1'b0; mode = 2'b01;
        shift_vec = 6'b101101;
        for (int i = 5; i >= 0; i--) begin
            scan_in = shift_vec[i]; cyc(1);
        end
        chk("shift_load", 32'(state), 32'h2D);
        for (int i = 5; i >= 0; i--) begin
            chk("shift_out", 32'(scan_out), 32'(shift_vec[i]));
            scan_in = 1'b0; cyc(1);
        end

        CLR = 1'b1; cyc(1);
        CLR = 1'b0; mode = 2'b00; pi = 7'd1; cyc(5);
        chk("func_state", 32'(state), 5);
        chk("func_po", 32'(po[5:0]), 4);

        // bist_start outside BIST mode must be ignored
        foreach (shift_vec[i]) begin
            pi = 7'(7'h13 * (i + 3)); bist_start = shift_vec[i]; cyc(1);
        end
        bist_start = 1'b0;
        chk("ignore_start", 32'(bist_busy), 0);
        mode = 2'b10; pi = 7'h55; cyc(3);
        mode = 2'b01; scan_in = 1'b1; cyc(2);
        mode = 2'b11; cyc(2);

        clear_and_launch();
        for (int i = 0; i < BIST_LEN; i++) begin
            chk("bist_busy_run", 32'(bist_busy), 1);
            chk("bist_valid_run", 32'(sig_valid), 0);
            cyc(1);
        end
        chk("bist_valid_done", 32'(sig_valid), 1);
        chk("bist_busy_done", 32'(bist_busy), 0);
        chk("bist_sig", 32'(sig), 32'hEE09);
        chk("bist_state", 32'(state), 32'h25);
        chk("bist_po", 32'(po), 32'h09);
        bist_start = 1'b1; cyc(1);
        bist_start = 1'b0;
        chk("done_one_cycle", 32'(sig_valid), 0);
        chk("done_start_ignored", 32'(bist_busy), 0);
        chk("sig_stable", 32'(sig), 32'hEE09);
        cyc(2);

        clear_and_launch();
        cyc(2);
        mode = 2'b10; cyc(1);
        chk("abort_busy", 32'(bist_busy), 0);
        chk("abort_sig", 32'(sig), 32'h21);
        cyc(3);
        chk("abort_valid", 32'(sig_valid), 0);
        chk("abort_sig_hold", 32'(sig), 32'h21);

        clear_and_launch();
        cyc(2);
        CLR = 1'b1; cyc(1);
        CLR = 1'b0;
        chk("clr_state", 32'(state), 0);
        chk("clr_po", 32'(po), 0);
        chk("clr_sig", 32'(sig), 0);
        chk("clr_busy", 32'(bist_busy), 0);
        chk("clr_valid", 32'(sig_valid), 0);
        bist_start = 1'b1; cyc(1);
        bist_start = 1'b0; cyc(BIST_LEN);
        chk("relaunch_sig", 32'(sig), 32'hEE09);
        chk("relaunch_valid", 32'(sig_valid), 1);
        cyc(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
